// File: rtl/cu_pkg.sv
// Shared definitions for the compute-unit register-file write-back slice.
//   DATA_WIDTH / ADDRESS_WIDTH / CNT_WIDTH : default widths
//   pipe_entry_t                           : one address-pipeline stage {v, addr}
//   HZCNT_MAX                              : saturation value of the hazard counter
package cu_pkg;

    localparam int unsigned DATA_WIDTH    = 16;
    localparam int unsigned ADDRESS_WIDTH = 4;
    localparam int unsigned CNT_WIDTH     = 16;

    typedef struct packed {
        logic                     v;
        logic [ADDRESS_WIDTH-1:0] addr;
    } pipe_entry_t;

    localparam logic [CNT_WIDTH-1:0] HZCNT_MAX = '1;

endpackage

// File: rtl/cu_rf_pipe.sv
// Two-stage pending write-back address pipeline (execute -> writeback).
//   clk_dcd   : core clock
//   rst       : synchronous active-high reset, clears both stages to invalid / addr 0
//   stall     : holds both stages when set
//   dec_entry : decode-stage {wreq, wadd} entering EX
//   ex_entry  : execute-stage entry
//   wb_entry  : writeback-stage entry
module cu_rf_pipe
    import cu_pkg::*;
(
    input  logic        clk_dcd,
    input  logic        rst,
    input  logic        stall,
    input  pipe_entry_t dec_entry,
    output pipe_entry_t ex_entry,
    output pipe_entry_t wb_entry
);

    // Advance on every non-stalled edge, freeze otherwise.
    always_ff @(posedge clk_dcd) begin
        if (rst) begin
            ex_entry <= '0;
            wb_entry <= '0;
        end else if (!stall) begin
            wb_entry <= ex_entry;
            ex_entry <= dec_entry;
        end
    end

endmodule

// File: rtl/cu_regfile_wb.sv
// Register-file end of the compute-unit crossbar interface.
//   clk_dcd       : core clock
//   rst           : synchronous active-high reset
//   ps_rf_stall   : sequencer stall, freezes pipeline and blocks writes
//   ps_rf_wreq    : decode-stage instruction writes a register
//   ps_rf_wadd    : decode-stage destination address
//   ps_rf_raddx/y : read addresses for the two operand ports
//   xb_rf_w_En    : crossbar write enable
//   xb_rf_dt      : crossbar write data
//   rf_xb_dtx/y   : read data (combinational, no bypass)
//   rf_ps_wadd_wb : writeback-stage address, used by the crossbar to forward
//   rf_ps_hazard  : read hits a pending execute-stage write (combinational)
//   rf_ps_wr_err  : sticky protocol-error flag
//   rf_ps_hzcnt   : saturating count of hazard cycles
module cu_regfile_wb #(
    parameter int unsigned DATA_WIDTH    = cu_pkg::DATA_WIDTH,
    parameter int unsigned ADDRESS_WIDTH = cu_pkg::ADDRESS_WIDTH,
    parameter int unsigned CNT_WIDTH     = cu_pkg::CNT_WIDTH
) (
    input  logic                     clk_dcd,
    input  logic                     rst,
    input  logic                     ps_rf_stall,
    input  logic                     ps_rf_wreq,
    input  logic [ADDRESS_WIDTH-1:0] ps_rf_wadd,
    input  logic [ADDRESS_WIDTH-1:0] ps_rf_raddx,
    input  logic [ADDRESS_WIDTH-1:0] ps_rf_raddy,
    input  logic                     xb_rf_w_En,
    input  logic [DATA_WIDTH-1:0]    xb_rf_dt,
    output logic [DATA_WIDTH-1:0]    rf_xb_dtx,
    output logic [DATA_WIDTH-1:0]    rf_xb_dty,
    output logic [ADDRESS_WIDTH-1:0] rf_ps_wadd_wb,
    output logic                     rf_ps_hazard,
    output logic                     rf_ps_wr_err,
    output logic [CNT_WIDTH-1:0]     rf_ps_hzcnt
);

    import cu_pkg::*;

    localparam int unsigned DEPTH   = 2 ** ADDRESS_WIDTH;
    localparam int unsigned PIPE_AW = $bits(pipe_entry_t) - 1;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    logic [DATA_WIDTH-1:0]    regs [DEPTH];
    pipe_entry_t              dec_entry;
    pipe_entry_t              ex_entry;
    pipe_entry_t              wb_entry;
    logic [ADDRESS_WIDTH-1:0] ex_addr;
    logic [ADDRESS_WIDTH-1:0] wb_addr;
    logic                     commit;
    logic                     proto_err;

    cu_rf_pipe u_pipe (
        .clk_dcd   (clk_dcd),
        .rst       (rst),
        .stall     (ps_rf_stall),
        .dec_entry (dec_entry),
        .ex_entry  (ex_entry),
        .wb_entry  (wb_entry)
    );

    // Stage decode and commit / error qualification.
    always_comb begin
        dec_entry      = '0;
        dec_entry.v    = ps_rf_wreq;
        dec_entry.addr = PIPE_AW'(ps_rf_wadd);
        ex_addr        = ADDRESS_WIDTH'(ex_entry.addr);
        wb_addr        = ADDRESS_WIDTH'(wb_entry.addr);
        commit         = wb_entry.v & xb_rf_w_En & ~ps_rf_stall;
        // Enable without a pending write, or a pending write with no enable.
        proto_err      = ~ps_rf_stall & (wb_entry.v ^ xb_rf_w_En);
    end

    // Read ports and hazard: WB-stage matches are forwarded by the crossbar.
    always_comb begin
        rf_xb_dtx     = regs[ps_rf_raddx];
        rf_xb_dty     = regs[ps_rf_raddy];
        rf_ps_wadd_wb = wb_addr;
        rf_ps_hazard  = ex_entry.v & ((ps_rf_raddx == ex_addr) | (ps_rf_raddy == ex_addr));
    end

    // Register array.
    always_ff @(posedge clk_dcd) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                regs[i] <= '0;
            end
        end else if (commit) begin
            regs[wb_addr] <= xb_rf_dt;
        end
    end

    // Sticky error flag and saturating hazard counter.
    always_ff @(posedge clk_dcd) begin
        if (rst) begin
            rf_ps_wr_err <= 1'b0;
            rf_ps_hzcnt  <= '0;
        end else begin
            if (proto_err) begin
                rf_ps_wr_err <= 1'b1;
            end
            if (rf_ps_hazard && (rf_ps_hzcnt != CNT_MAX)) begin
                rf_ps_hzcnt <= rf_ps_hzcnt + CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_cu_regfile_wb.sv
// Directed self-checking bench for cu_regfile_wb.
module tb_cu_regfile_wb;

    logic        clk_dcd;
    logic        rst;
    logic        ps_rf_stall;
    logic        ps_rf_wreq;
    logic [3:0]  ps_rf_wadd;
    logic [3:0]  ps_rf_raddx;
    logic [3:0]  ps_rf_raddy;
    logic        xb_rf_w_En;
    logic [15:0] xb_rf_dt;
    logic [15:0] rf_xb_dtx;
    logic [15:0] rf_xb_dty;
    logic [3:0]  rf_ps_wadd_wb;
    logic        rf_ps_hazard;
    logic        rf_ps_wr_err;
    logic [15:0] rf_ps_hzcnt;

    int checks = 0;
    int errors = 0;

    cu_regfile_wb dut (
        .clk_dcd       (clk_dcd),
        .rst           (rst),
        .ps_rf_stall   (ps_rf_stall),
        .ps_rf_wreq    (ps_rf_wreq),
        .ps_rf_wadd    (ps_rf_wadd),
        .ps_rf_raddx   (ps_rf_raddx),
        .ps_rf_raddy   (ps_rf_raddy),
        .xb_rf_w_En    (xb_rf_w_En),
        .xb_rf_dt      (xb_rf_dt),
        .rf_xb_dtx     (rf_xb_dtx),
        .rf_xb_dty     (rf_xb_dty),
        .rf_ps_wadd_wb (rf_ps_wadd_wb),
        .rf_ps_hazard  (rf_ps_hazard),
        .rf_ps_wr_err  (rf_ps_wr_err),
        .rf_ps_hzcnt   (rf_ps_hzcnt)
    );

    initial clk_dcd = 1'b0;
    always #5 clk_dcd = ~clk_dcd;

    // Inputs change 1 time unit after the rising edge; checks sample 1 unit later.
    task automatic tick();
        @(posedge clk_dcd);
        #1;
    endtask

    task automatic idle();
        ps_rf_stall = 1'b0;
        ps_rf_wreq  = 1'b0;
        ps_rf_wadd  = 4'd0;
        xb_rf_w_En  = 1'b0;
        xb_rf_dt    = 16'h0000;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle();
        ps_rf_raddx = 4'd0;
        ps_rf_raddy = 4'd0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        for (int i = 0; i < 16; i++) begin
            ps_rf_raddx = 4'(i);
            ps_rf_raddy = 4'(15 - i);
            #1;
            checks++;
            if (rf_xb_dtx !== 16'h0000) begin
                errors++;
                $display("FAIL reset_dtx[%0d]: got %h expected 0000", i, rf_xb_dtx);
            end
            checks++;
            if (rf_xb_dty !== 16'h0000) begin
                errors++;
                $display("FAIL reset_dty[%0d]: got %h expected 0000", 15 - i, rf_xb_dty);
            end
        end
        ps_rf_raddx = 4'd0;
        ps_rf_raddy = 4'd0;
        #1;
        checks++;
        if (rf_ps_hazard !== 1'b0) begin
            errors++;
            $display("FAIL reset_hazard: got %b expected 0", rf_ps_hazard);
        end
        checks++;
        if (rf_ps_wr_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_err: got %b expected 0", rf_ps_wr_err);
        end
        checks++;
        if (rf_ps_hzcnt !== 16'h0000) begin
            errors++;
            $display("FAIL reset_hzcnt: got %h expected 0000", rf_ps_hzcnt);
        end
    endtask

    task automatic test_basic_write();
        do_reset();
        ps_rf_wreq = 1'b1;
        ps_rf_wadd = 4'd3;
        tick();
        idle();
        tick();
        xb_rf_w_En  = 1'b1;
        xb_rf_dt    = 16'hA5A5;
        ps_rf_raddx = 4'd3;
        #1;
        checks++;
        if (rf_xb_dtx !== 16'h0000) begin
            errors++;
            $display("FAIL basic_old_read: got %h expected 0000", rf_xb_dtx);
        end
        checks++;
        if (rf_ps_wadd_wb !== 4'd3) begin
            errors++;
            $display("FAIL basic_wadd_wb: got %0d expected 3", rf_ps_wadd_wb);
        end
        tick();
        idle();
        #1;
        checks++;
        if (rf_xb_dtx !== 16'hA5A5) begin
            errors++;
            $display("FAIL basic_new_read: got %h expected a5a5", rf_xb_dtx);
        end
        checks++;
        if (rf_ps_wr_err !== 1'b0) begin
            errors++;
            $display("FAIL basic_err: got %b expected 0", rf_ps_wr_err);
        end
    endtask

    task automatic test_stall();
        do_reset();
        ps_rf_wreq = 1'b1;
        ps_rf_wadd = 4'd3;
        tick();
        idle();
        ps_rf_stall = 1'b1;
        tick();
        ps_rf_stall = 1'b1;
        xb_rf_w_En  = 1'b1;
        xb_rf_dt    = 16'hBEEF;
        tick();
        idle();
        ps_rf_raddx = 4'd3;
        #1;
        checks++;
        if (rf_xb_dtx !== 16'h0000) begin
            errors++;
            $display("FAIL stall_pulse_no_write: got %h expected 0000", rf_xb_dtx);
        end
        checks++;
        if (rf_ps_wadd_wb !== 4'd0) begin
            errors++;
            $display("FAIL stall_wb_held: got %0d expected 0", rf_ps_wadd_wb);
        end
        tick();
        xb_rf_w_En = 1'b1;
        xb_rf_dt   = 16'h1234;
        #1;
        checks++;
        if (rf_ps_wadd_wb !== 4'd3) begin
            errors++;
            $display("FAIL stall_wadd_wb: got %0d expected 3", rf_ps_wadd_wb);
        end
        tick();
        idle();
        #1;
        checks++;
        if (rf_xb_dtx !== 16'h1234) begin
            errors++;
            $display("FAIL stall_commit: got %h expected 1234", rf_xb_dtx);
        end
        checks++;
        if (rf_ps_wr_err !== 1'b0) begin
            errors++;
            $display("FAIL stall_err: got %b expected 0", rf_ps_wr_err);
        end
    endtask

    task automatic test_hazard();
        do_reset();
        ps_rf_wreq = 1'b1;
        ps_rf_wadd = 4'd5;
        #1;
        checks++;
        if (rf_ps_hazard !== 1'b0) begin
            errors++;
            $display("FAIL hazard_c0: got %b expected 0", rf_ps_hazard);
        end
        tick();
        idle();
        ps_rf_raddy = 4'd5;
        #1;
        checks++;
        if (rf_ps_hazard !== 1'b1) begin
            errors++;
            $display("FAIL hazard_c1: got %b expected 1", rf_ps_hazard);
        end
        tick();
        xb_rf_w_En = 1'b1;
        xb_rf_dt   = 16'h0F0F;
        #1;
        checks++;
        if (rf_ps_hazard !== 1'b0) begin
            errors++;
            $display("FAIL hazard_c2_wb: got %b expected 0", rf_ps_hazard);
        end
        checks++;
        if (rf_ps_hzcnt !== 16'd1) begin
            errors++;
            $display("FAIL hazard_cnt: got %0d expected 1", rf_ps_hzcnt);
        end
        tick();
        idle();
        #1;
        checks++;
        if (rf_xb_dty !== 16'h0F0F) begin
            errors++;
            $display("FAIL hazard_commit: got %h expected 0f0f", rf_xb_dty);
        end
        checks++;
        if (rf_ps_hzcnt !== 16'd1) begin
            errors++;
            $display("FAIL hazard_cnt_hold: got %0d expected 1", rf_ps_hzcnt);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        ps_rf_wreq = 1'b1;
        ps_rf_wadd = 4'd4;
        tick();
        ps_rf_wreq = 1'b1;
        ps_rf_wadd = 4'd4;
        tick();
        idle();
        xb_rf_w_En  = 1'b1;
        xb_rf_dt    = 16'h1111;
        ps_rf_raddy = 4'd4;
        #1;
        checks++;
        if (rf_ps_hazard !== 1'b1) begin
            errors++;
            $display("FAIL b2b_ex_valid: got %b expected 1", rf_ps_hazard);
        end
        tick();
        xb_rf_w_En = 1'b1;
        xb_rf_dt   = 16'h2222;
        #1;
        checks++;
        if (rf_xb_dty !== 16'h1111) begin
            errors++;
            $display("FAIL b2b_first: got %h expected 1111", rf_xb_dty);
        end
        tick();
        idle();
        #1;
        checks++;
        if (rf_xb_dty !== 16'h2222) begin
            errors++;
            $display("FAIL b2b_last_wins: got %h expected 2222", rf_xb_dty);
        end
        checks++;
        if (rf_ps_wr_err !== 1'b0) begin
            errors++;
            $display("FAIL b2b_err: got %b expected 0", rf_ps_wr_err);
        end
    endtask

    task automatic test_err_no_pending();
        do_reset();
        xb_rf_w_En = 1'b1;
        xb_rf_dt   = 16'hFFFF;
        #1;
        checks++;
        if (rf_ps_wr_err !== 1'b0) begin
            errors++;
            $display("FAIL errnp_before: got %b expected 0", rf_ps_wr_err);
        end
        tick();
        idle();
        #1;
        checks++;
        if (rf_ps_wr_err !== 1'b1) begin
            errors++;
            $display("FAIL errnp_flag: got %b expected 1", rf_ps_wr_err);
        end
        for (int i = 0; i < 16; i++) begin
            ps_rf_raddx = 4'(i);
            #1;
            checks++;
            if (rf_xb_dtx !== 16'h0000) begin
                errors++;
                $display("FAIL errnp_reg[%0d]: got %h expected 0000", i, rf_xb_dtx);
            end
        end
        ps_rf_raddx = 4'd0;
    endtask

    task automatic test_err_dropped();
        do_reset();
        ps_rf_wreq = 1'b1;
        ps_rf_wadd = 4'd7;
        tick();
        idle();
        tick();
        #1;
        checks++;
        if (rf_ps_wr_err !== 1'b0) begin
            errors++;
            $display("FAIL errdrop_before: got %b expected 0", rf_ps_wr_err);
        end
        tick();
        ps_rf_raddx = 4'd7;
        #1;
        checks++;
        if (rf_ps_wr_err !== 1'b1) begin
            errors++;
            $display("FAIL errdrop_flag: got %b expected 1", rf_ps_wr_err);
        end
        checks++;
        if (rf_xb_dtx !== 16'h0000) begin
            errors++;
            $display("FAIL errdrop_reg: got %h expected 0000", rf_xb_dtx);
        end
        tick();
        #1;
        checks++;
        if (rf_ps_wr_err !== 1'b1) begin
            errors++;
            $display("FAIL errdrop_sticky: got %b expected 1", rf_ps_wr_err);
        end
        ps_rf_raddx = 4'd0;
    endtask

    task automatic test_saturation_and_reset();
        do_reset();
        ps_rf_wreq = 1'b1;
        ps_rf_wadd = 4'd2;
        tick();
        ps_rf_wreq = 1'b1;
        ps_rf_wadd = 4'd2;
        tick();
        idle();
        ps_rf_stall = 1'b1;
        ps_rf_raddx = 4'd2;
        #1;
        checks++;
        if (rf_ps_hazard !== 1'b1) begin
            errors++;
            $display("FAIL sat_hazard: got %b expected 1", rf_ps_hazard);
        end
        checks++;
        if (rf_ps_wadd_wb !== 4'd2) begin
            errors++;
            $display("FAIL sat_wadd_wb: got %0d expected 2", rf_ps_wadd_wb);
        end
        repeat (65534) tick();
        #1;
        checks++;
        if (rf_ps_hzcnt !== 16'hFFFE) begin
            errors++;
            $display("FAIL sat_cnt_fffe: got %h expected fffe", rf_ps_hzcnt);
        end
        repeat (3) tick();
        #1;
        checks++;
        if (rf_ps_hzcnt !== 16'hFFFF) begin
            errors++;
            $display("FAIL sat_cnt_ffff: got %h expected ffff", rf_ps_hzcnt);
        end
        checks++;
        if (rf_ps_wr_err !== 1'b0) begin
            errors++;
            $display("FAIL sat_err: got %b expected 0", rf_ps_wr_err);
        end
        // Reset with EX and WB both valid and a data pulse in the reset cycle.
        rst         = 1'b1;
        ps_rf_stall = 1'b0;
        xb_rf_w_En  = 1'b1;
        xb_rf_dt    = 16'hAAAA;
        tick();
        rst = 1'b0;
        idle();
        #1;
        checks++;
        if (rf_ps_wr_err !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_err: got %b expected 0", rf_ps_wr_err);
        end
        checks++;
        if (rf_ps_hzcnt !== 16'h0000) begin
            errors++;
            $display("FAIL rstmid_hzcnt: got %h expected 0000", rf_ps_hzcnt);
        end
        checks++;
        if (rf_ps_hazard !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_hazard: got %b expected 0", rf_ps_hazard);
        end
        checks++;
        if (rf_ps_wadd_wb !== 4'd0) begin
            errors++;
            $display("FAIL rstmid_wadd_wb: got %0d expected 0", rf_ps_wadd_wb);
        end
        checks++;
        if (rf_xb_dtx !== 16'h0000) begin
            errors++;
            $display("FAIL rstmid_reg: got %h expected 0000", rf_xb_dtx);
        end
        tick();
        #1;
        checks++;
        if (rf_xb_dtx !== 16'h0000) begin
            errors++;
            $display("FAIL rstmid_reg_after: got %h expected 0000", rf_xb_dtx);
        end
        checks++;
        if (rf_ps_wr_err !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_err_after: got %b expected 0", rf_ps_wr_err);
        end
    endtask

    initial begin
        rst         = 1'b1;
        ps_rf_stall = 1'b0;
        ps_rf_wreq  = 1'b0;
        ps_rf_wadd  = 4'd0;
        ps_rf_raddx = 4'd0;
        ps_rf_raddy = 4'd0;
        xb_rf_w_En  = 1'b0;
        xb_rf_dt    = 16'h0000;
        test_reset();
        test_basic_write();
        test_stall();
        test_hazard();
        test_back_to_back();
        test_err_no_pending();
        test_err_dropped();
        test_saturation_and_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
